// File: rtl/filter_sel_pkg.sv
// Shared types and constants for the interpolation-output selector pipeline.
// Holds the FSM state encoding and the select-width helper.
package filter_sel_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 14;
    localparam int N_IN_DEF   = 15;

    // Index 0 is reserved for "none", so the field must hold the values 0..n.
    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/filter_sel_pipe_if.sv
// Bundle of the filter-bank input channel and the cost-stage output channel.
// The slave modport faces the selector and the master modport faces its environment.
interface filter_sel_pipe_if
    import filter_sel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_IN   = N_IN_DEF
);
    localparam int SEL_W = sel_width(N_IN);

    logic [N_IN*DATA_W-1:0]    data_in;
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic signed [DATA_W-1:0]  data_out;
    logic [SEL_W-1:0]          sel_out;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  data_in, in_valid, mode, select, out_ready,
        output in_ready, data_out, sel_out, out_last, out_valid
    );

    modport master (
        output data_in, in_valid, mode, select, out_ready,
        input  in_ready, data_out, sel_out, out_last, out_valid
    );

endinterface

// File: rtl/mux_sel_n.sv
// Combinational N:1 selector over a packed candidate bank, indexed from 1.
// Index 0 and indices above N_IN produce zero.
module mux_sel_n
    import filter_sel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_IN   = N_IN_DEF,
    parameter int SEL_W  = sel_width(N_IN)
) (
    input  logic [N_IN*DATA_W-1:0]   bank,
    input  logic [SEL_W-1:0]         sel,
    output logic signed [DATA_W-1:0] y
);

    // One-hot compare against every legal index; no match leaves the zero default.
    always_comb begin
        y = '0;
        for (int k = 1; k <= N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                y = bank[k*DATA_W-1 -: DATA_W];
            end else begin
                y = y;
            end
        end
    end

endmodule

// File: rtl/filter_sel_pipe.sv
// Registered selector between the interpolation filter bank and the cost stage.
// Direct mode emits one chosen candidate; sweep mode emits all candidates in index order.
module filter_sel_pipe
    import filter_sel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_IN   = N_IN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    filter_sel_pipe_if.slave  sp
);

    localparam int SEL_W = sel_width(N_IN);

    state_t                    state_r, state_nxt_s;
    logic [SEL_W-1:0]          idx_r, idx_nxt_s;
    logic [N_IN*DATA_W-1:0]    hold_r, hold_nxt_s;
    logic signed [DATA_W-1:0]  data_out_r, data_nxt_s;
    logic [SEL_W-1:0]          sel_out_r, sel_nxt_s;
    logic                      out_last_r, last_nxt_s;
    logic                      out_valid_r, valid_nxt_s;

    logic signed [DATA_W-1:0]  mux_dir_s;
    logic signed [DATA_W-1:0]  mux_swp_s;
    logic                      in_ready_s;
    logic                      accept_s;

    mux_sel_n #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .SEL_W  (SEL_W)
    ) u_mux_direct (
        .bank (sp.data_in),
        .sel  (sp.select),
        .y    (mux_dir_s)
    );

    mux_sel_n #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .SEL_W  (SEL_W)
    ) u_mux_sweep (
        .bank (hold_r),
        .sel  (idx_r),
        .y    (mux_swp_s)
    );

    // Ready is withheld for the whole sweep except through the slot freed by a consumed output.
    always_comb begin
        in_ready_s = (state_r == S_IDLE) && (!out_valid_r || sp.out_ready);
        accept_s   = sp.in_valid && in_ready_s;
    end

    // Next-state and next-output decode; every register holds unless a transfer moves it.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        hold_nxt_s  = hold_r;
        data_nxt_s  = data_out_r;
        sel_nxt_s   = sel_out_r;
        last_nxt_s  = out_last_r;
        valid_nxt_s = out_valid_r;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (!sp.mode) begin
                        data_nxt_s  = mux_dir_s;
                        sel_nxt_s   = sp.select;
                        last_nxt_s  = 1'b1;
                        valid_nxt_s = 1'b1;
                    end else begin
                        hold_nxt_s  = sp.data_in;
                        data_nxt_s  = sp.data_in[DATA_W-1:0];
                        sel_nxt_s   = SEL_W'(1);
                        last_nxt_s  = (N_IN == 1);
                        valid_nxt_s = 1'b1;
                        idx_nxt_s   = SEL_W'(2);
                        state_nxt_s = (N_IN > 1) ? S_SWEEP : S_IDLE;
                    end
                end else if (out_valid_r && sp.out_ready) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end

            S_SWEEP: begin
                // Beat idx-1 is leaving now, so hold[idx] takes its place.
                if (sp.out_ready) begin
                    data_nxt_s = mux_swp_s;
                    sel_nxt_s  = idx_r;
                    last_nxt_s = (idx_r == SEL_W'(N_IN));
                    if (idx_r == SEL_W'(N_IN)) begin
                        state_nxt_s = S_IDLE;
                        idx_nxt_s   = SEL_W'(1);
                    end else begin
                        idx_nxt_s   = idx_r + SEL_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end

            default: begin
                state_nxt_s = S_IDLE;
                idx_nxt_s   = SEL_W'(1);
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, sweep bank and output registers; reset discards any sweep in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            idx_r       <= SEL_W'(1);
            hold_r      <= '0;
            data_out_r  <= '0;
            sel_out_r   <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            hold_r      <= hold_nxt_s;
            data_out_r  <= data_nxt_s;
            sel_out_r   <= sel_nxt_s;
            out_last_r  <= last_nxt_s;
            out_valid_r <= valid_nxt_s;
        end
    end

    assign sp.in_ready  = in_ready_s;
    assign sp.data_out  = data_out_r;
    assign sp.sel_out   = sel_out_r;
    assign sp.out_last  = out_last_r;
    assign sp.out_valid = out_valid_r;

endmodule

// File: tb/tb_filter_sel_pipe.sv
// Directed bench for filter_sel_pipe: a 15-input build plus a 12-input build for range checks.
module tb_filter_sel_pipe;

    localparam int DW = 14;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;
    int cand [1:15];

    filter_sel_pipe_if #(.DATA_W(DW), .N_IN(15)) sp ();
    filter_sel_pipe_if #(.DATA_W(DW), .N_IN(12)) s12 ();

    filter_sel_pipe #(.DATA_W(DW), .N_IN(15)) dut (
        .clk (clk),
        .rst (rst),
        .sp  (sp.slave)
    );

    filter_sel_pipe #(.DATA_W(DW), .N_IN(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .sp  (s12.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pack cand[] into both DUT input buses.
    task automatic load();
        logic [15*DW-1:0] v;
        v = '0;
        for (int k = 1; k <= 15; k++) v[k*DW-1 -: DW] = DW'(cand[k]);
        sp.data_in  = v;
        s12.data_in = v[12*DW-1:0];
    endtask

    task automatic fill(input int mul);
        for (int k = 1; k <= 15; k++) cand[k] = k * mul;
    endtask

    task automatic chk_out(input string tag, input int d, input int s, input int l, input int v);
        chk({tag, "_data"},  sp.data_out,  d);
        chk({tag, "_sel"},   sp.sel_out,   s);
        chk({tag, "_last"},  sp.out_last,  l);
        chk({tag, "_valid"}, sp.out_valid, v);
    endtask

    initial begin
        int e;
        int cyc;
        logic rdy;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        sp.in_valid = 1'b0;  sp.mode = 1'b0;  sp.select = '0;  sp.out_ready = 1'b1;
        s12.in_valid = 1'b0; s12.mode = 1'b0; s12.select = '0; s12.out_ready = 1'b1;
        fill(100);
        load();
        repeat (2) @(negedge clk);
        chk_out("por", 0, 0, 0, 0);
        rst = 1'b0;

        // Direct select 5, then a mid-cycle reset clears everything at once.
        sp.in_valid = 1'b1; sp.select = 4'd5;
        #1 chk("idle_inrdy", sp.in_ready, 1);
        @(negedge clk);
        chk_out("dir5", 500, 5, 1, 1);
        #2 rst = 1'b1;
        #1 chk_out("rst_async", 0, 0, 0, 0);
        sp.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_inrdy", sp.in_ready, 1);

        // Back-to-back direct beats: select 3 then select 0.
        @(negedge clk);
        sp.in_valid = 1'b1; sp.select = 4'd3;
        @(negedge clk);
        chk_out("dir3", 300, 3, 1, 1);
        sp.select = 4'd0;
        @(negedge clk);
        chk_out("dir0", 0, 0, 1, 1);

        // Signed extreme on candidate 15; the 12-input build treats 15 as out of range.
        cand[15] = -8192;
        load();
        sp.select = 4'd15;
        s12.in_valid = 1'b1; s12.select = 4'd15;
        @(negedge clk);
        chk_out("neg15", -8192, 15, 1, 1);
        chk("n12_sel15_data", s12.data_out, 0);
        chk("n12_sel15_sel", s12.sel_out, 15);
        sp.select = 4'd14; s12.select = 4'd12;
        @(negedge clk);
        chk_out("dir14", 1400, 14, 1, 1);
        chk("n12_sel12_data", s12.data_out, 1200);
        sp.in_valid = 1'b0; s12.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", sp.out_valid, 0);

        // Backpressure: the beat holds and inputs are refused until released.
        fill(100);
        load();
        sp.out_ready = 1'b0; sp.in_valid = 1'b1; sp.select = 4'd7;
        @(negedge clk);
        sp.select = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_inrdy", sp.in_ready, 0);
            chk_out("bp_hold", 700, 7, 1, 1);
            @(negedge clk);
        end
        sp.out_ready = 1'b1;
        #1 chk("bp_release_inrdy", sp.in_ready, 1);
        @(negedge clk);
        chk_out("bp_next", 900, 9, 1, 1);
        sp.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain", sp.out_valid, 0);

        // Sweep with candidate k = -k, a second sweep queued behind it.
        fill(-1);
        load();
        sp.mode = 1'b1; sp.in_valid = 1'b1;
        @(negedge clk);
        fill(7);
        load();
        for (int b = 1; b <= 15; b++) begin
            chk_out("swp1", -b, b, (b == 15) ? 1 : 0, 1);
            chk("swp1_inrdy", sp.in_ready, (b == 15) ? 1 : 0);
            @(negedge clk);
        end
        chk_out("swp2_first", 7, 1, 0, 1);
        sp.in_valid = 1'b0;

        // Second sweep under random backpressure: no loss, no duplication.
        e = 1;
        cyc = 0;
        while (e <= 15 && cyc < 200) begin
            rdy = 1'($urandom_range(0, 1));
            sp.out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) e++;
            if (e <= 15) chk_out("swp2", 7 * e, e, (e == 15) ? 1 : 0, 1);
            else chk("swp2_end_valid", sp.out_valid, 0);
        end
        if (cyc >= 200) chk("swp2_timeout", 0, 1);
        sp.out_ready = 1'b1;

        // Reset during a sweep at index 7.
        fill(-1);
        load();
        sp.in_valid = 1'b1;
        @(negedge clk);
        sp.in_valid = 1'b0; sp.mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_sel7", sp.sel_out, 7);
        #2 rst = 1'b1;
        #1 chk_out("mid_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        fill(100);
        load();
        sp.select = 4'd5; sp.in_valid = 1'b1;
        @(negedge clk);
        chk_out("post_rst", 500, 5, 1, 1);
        sp.in_valid = 1'b0;
        @(negedge clk);
        chk("post_drain", sp.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
